// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access stage. Takes the decoder memory controls and the
//   ALU address, runs one request/grant/response transaction on a 64-bit
//   data bus, and holds the core with `stall` until the access completes.
//   Loads come back aligned and sign- or zero-extended in `load_data`.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   mem_read      load request
//   mem_write     store request (wins when both requests are high)
//   mem_sign      1 = zero-extend, 0 = sign-extend
//   mem_width     00 byte, 01 half, 10 word, 11 double
//   addr          byte address from the ALU
//   store_data    rs2 value for stores
//   stall         hold PC and pipeline (combinational)
//   load_data     extended load result (registered, held until next load)
//   misaligned    fault pulse while a misaligned access sits in IDLE
//   bus_*         request/grant/response data bus
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  defined: misaligned accesses are trapped and
//                         raise `misaligned`; no bus transaction is issued.
//                         undefined: `misaligned` is 0 and the low address
//                         bits are truncated to natural alignment.

module load_store_unit #(
    parameter int REG_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_sign,
    input  logic [1:0]            mem_width,
    input  logic [REG_WIDTH-1:0]  addr,
    input  logic [REG_WIDTH-1:0]  store_data,
    output logic                  stall,
    output logic [REG_WIDTH-1:0]  load_data,
    output logic                  misaligned,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_be,
    output logic [REG_WIDTH-1:0]  bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [REG_WIDTH-1:0]  bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;

    logic                   we_q;
    logic                   sign_q;
    logic [1:0]             width_q;
    logic [2:0]             off_q;
    logic [ADDR_WIDTH-1:0]  bus_addr_q;
    logic [7:0]             bus_be_q;
    logic [REG_WIDTH-1:0]   bus_wdata_q;
    logic [REG_WIDTH-1:0]   load_data_q;

    logic                   access;
    logic [2:0]             off;
    logic [2:0]             eff_off;
    logic                   misalign_cond;
    logic [7:0]             be_d;
    logic [REG_WIDTH-1:0]   wdata_d;
    logic [REG_WIDTH-1:0]   rdata_shifted;
    logic [REG_WIDTH-1:0]   load_ext;
    logic                   unused_addr_hi;

    assign access = mem_read | mem_write;
    assign off    = addr[2:0];

    // Only the low ADDR_WIDTH address bits reach the bus.
    assign unused_addr_hi = ^addr[REG_WIDTH-1:ADDR_WIDTH];

    // Misalignment check, or natural-alignment truncation when trapping
    // is compiled out.
    always_comb begin
        misalign_cond = 1'b0;
        eff_off       = off;
`ifdef LSU_MISALIGN_TRAP_EN
        case (mem_width)
            2'b00:   misalign_cond = 1'b0;
            2'b01:   misalign_cond = off[0];
            2'b10:   misalign_cond = |off[1:0];
            default: misalign_cond = |off;
        endcase
`else
        case (mem_width)
            2'b00:   eff_off = off;
            2'b01:   eff_off = {off[2:1], 1'b0};
            2'b10:   eff_off = {off[2], 2'b00};
            default: eff_off = 3'b000;
        endcase
`endif
    end

    always_comb begin
        case (mem_width)
            2'b00:   be_d = 8'h01 << eff_off;
            2'b01:   be_d = 8'h03 << eff_off;
            2'b10:   be_d = 8'h0F << eff_off;
            default: be_d = 8'hFF;
        endcase
        wdata_d = store_data << {eff_off, 3'b000};
    end

    // Extract the addressed lane from the read data and extend it.
    always_comb begin
        rdata_shifted = bus_rdata >> {off_q, 3'b000};
        case (width_q)
            2'b00:   load_ext = {{(REG_WIDTH-8){~sign_q & rdata_shifted[7]}},
                                 rdata_shifted[7:0]};
            2'b01:   load_ext = {{(REG_WIDTH-16){~sign_q & rdata_shifted[15]}},
                                 rdata_shifted[15:0]};
            2'b10:   load_ext = {{(REG_WIDTH-32){~sign_q & rdata_shifted[31]}},
                                 rdata_shifted[31:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (access && !misalign_cond) state_d = REQ;
            REQ:  if (bus_gnt) state_d = we_q ? DONE : WAIT;
            WAIT: if (bus_rvalid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            width_q     <= '0;
            off_q       <= '0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && access && !misalign_cond) begin
                we_q        <= mem_write;
                sign_q      <= mem_sign;
                width_q     <= mem_width;
                off_q       <= eff_off;
                bus_addr_q  <= {addr[ADDR_WIDTH-1:3], 3'b000};
                bus_be_q    <= be_d;
                bus_wdata_q <= wdata_d;
            end
            if (state_q == WAIT && bus_rvalid) begin
                load_data_q <= load_ext;
            end
        end
    end

    assign stall      = access & ~misalign_cond & (state_q != DONE);
    assign misaligned = access & misalign_cond & (state_q == IDLE);
    assign bus_req    = (state_q == REQ);
    assign bus_we     = we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed accesses with a scoreboard of
// expected load_data values, checked when each access completes.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic        mem_sign;
    logic [1:0]  mem_width;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic        stall;
    logic [63:0] load_data;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [7:0]  bus_be;
    logic [63:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_load = '0;

    load_store_unit #(
        .REG_WIDTH  (64),
        .ADDR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_sign   (mem_sign),
        .mem_width  (mem_width),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .misaligned (misaligned),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one access, acts as the bus slave with the given grant and
    // response delays, checks bus fields every REQ cycle, and on the
    // completion cycle compares load_data against the scoreboard and the
    // number of stalled cycles against the expected latency.
    task automatic run_access(
        input string       tag,
        input logic        rd,
        input logic        wr,
        input logic        sgn,
        input logic [1:0]  w,
        input logic [63:0] a,
        input logic [63:0] sd,
        input logic [63:0] rdat,
        input int          gnt_dly,
        input int          rv_dly,
        input logic [31:0] exp_addr,
        input logic [7:0]  exp_be,
        input logic [63:0] exp_wdata,
        input logic [63:0] exp_load
    );
        int          stall_cnt = 0;
        int          rq = 0;
        int          wt = 0;
        bit          granted = 1'b0;
        bit          done = 1'b0;
        int          exp_stall;
        logic [63:0] exp_val;

        exp_stall = wr ? (2 + gnt_dly) : (3 + gnt_dly + rv_dly);

        @(posedge clk); #1;
        mem_read   = rd;
        mem_write  = wr;
        mem_sign   = sgn;
        mem_width  = w;
        addr       = a;
        store_data = sd;
        bus_rdata  = rdat;
        if (wr) begin
            exp_q.push_back(last_load);
        end else begin
            exp_q.push_back(exp_load);
            last_load = exp_load;
        end

        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            if (c == 0) begin
                check($sformatf("%s.misaligned", tag), misaligned, 1'b0);
                check($sformatf("%s.idle_req", tag), bus_req, 1'b0);
            end
            if (!stall) begin
                done = 1'b1;
                exp_val = exp_q.pop_front();
                check($sformatf("%s.load_data", tag), load_data, exp_val);
                check($sformatf("%s.stall_cycles", tag), stall_cnt, exp_stall);
            end else begin
                stall_cnt++;
                if (bus_req) begin
                    check($sformatf("%s.bus_addr", tag), bus_addr, exp_addr);
                    check($sformatf("%s.bus_be", tag), bus_be, exp_be);
                    check($sformatf("%s.bus_wdata", tag), bus_wdata, exp_wdata);
                    check($sformatf("%s.bus_we", tag), bus_we, wr);
                    if (rq == gnt_dly) begin
                        bus_gnt = 1'b1;
                        granted = 1'b1;
                    end
                    rq++;
                end else if (granted && !wr) begin
                    if (wt == rv_dly) bus_rvalid = 1'b1;
                    wt++;
                end
            end
        end
        check($sformatf("%s.completed", tag), done, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        mem_sign   = 1'b0;
        mem_width  = 2'b00;
        addr       = '0;
        store_data = '0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;

        // Reset held for two cycles with a load presented.
        @(negedge clk);
        check("rst.bus_req",    bus_req,    1'b0);
        check("rst.bus_we",     bus_we,     1'b0);
        check("rst.bus_addr",   bus_addr,   32'h0);
        check("rst.bus_be",     bus_be,     8'h00);
        check("rst.bus_wdata",  bus_wdata,  64'h0);
        check("rst.load_data",  load_data,  64'h0);
        check("rst.misaligned", misaligned, 1'b0);
        @(posedge clk); #1;
        rst      = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        check("post_rst.stall",   stall,   1'b0);
        check("post_rst.bus_req", bus_req, 1'b0);

        // LB / LBU at byte offset 3.
        run_access("lb", 1'b1, 1'b0, 1'b0, 2'b00, 64'h1003, 64'h0,
                   64'h0000_0000_8000_0000, 0, 0,
                   32'h1000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        run_access("lbu", 1'b1, 1'b0, 1'b1, 2'b00, 64'hFFFF_FFFF_0000_1003, 64'h0,
                   64'h0000_0000_8000_0000, 0, 0,
                   32'h1000, 8'h08, 64'h0, 64'h0000_0000_0000_0080);

        // SH with grant delayed by three cycles.
        run_access("sh", 1'b0, 1'b1, 1'b0, 2'b01, 64'h2006, 64'h1234,
                   64'h0, 3, 0,
                   32'h2000, 8'hC0, 64'h1234_0000_0000_0000, 64'h0);

        // Half/word/double loads with assorted delays and extensions.
        run_access("lh", 1'b1, 1'b0, 1'b0, 2'b01, 64'h0102, 64'h0,
                   64'h0000_0000_ABCD_0000, 1, 2,
                   32'h0100, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD);
        run_access("lwu", 1'b1, 1'b0, 1'b1, 2'b10, 64'h0104, 64'h0,
                   64'h8765_4321_0000_0000, 0, 1,
                   32'h0100, 8'hF0, 64'h0, 64'h0000_0000_8765_4321);
        run_access("lw", 1'b1, 1'b0, 1'b0, 2'b10, 64'h0104, 64'h0,
                   64'h8765_4321_0000_0000, 0, 0,
                   32'h0100, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321);
        run_access("ld", 1'b1, 1'b0, 1'b0, 2'b11, 64'h0208, 64'h0,
                   64'h0123_4567_89AB_CDEF, 0, 2,
                   32'h0208, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF);

        // Read and write together: store wins, load_data untouched.
        run_access("sw_rdwr", 1'b1, 1'b1, 1'b0, 2'b10, 64'h3004, 64'hDEAD_BEEF_CAFE_F00D,
                   64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
                   32'h3000, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'h0);
        run_access("sb", 1'b0, 1'b1, 1'b0, 2'b00, 64'h4007, 64'h0000_0000_0000_00A5,
                   64'h0, 1, 0,
                   32'h4000, 8'h80, 64'hA500_0000_0000_0000, 64'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned LW is trapped in IDLE.
        @(posedge clk); #1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        mem_sign  = 1'b0;
        mem_width = 2'b10;
        addr      = 64'h1002;
        @(negedge clk);
        check("mis.misaligned", misaligned, 1'b1);
        check("mis.stall",      stall,      1'b0);
        check("mis.bus_req",    bus_req,    1'b0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        check("mis.pulse_end",  misaligned, 1'b0);
        check("mis.no_req",     bus_req,    1'b0);
        check("mis.load_data",  load_data,  last_load);
`else
        // Misaligned LW is truncated to natural alignment.
        run_access("lw_trunc", 1'b1, 1'b0, 1'b0, 2'b10, 64'h1002, 64'h0,
                   64'h1122_3344_8899_AABB, 0, 0,
                   32'h1000, 8'h0F, 64'h0, 64'hFFFF_FFFF_8899_AABB);
`endif

        // Reset while waiting for a load response; the late response is dropped.
        @(posedge clk); #1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        mem_sign  = 1'b0;
        mem_width = 2'b11;
        addr      = 64'h3000;
        bus_rdata = 64'hFEED_FACE_0BAD_F00D;
        @(negedge clk);
        @(negedge clk);
        check("rstw.bus_req",  bus_req,  1'b1);
        check("rstw.bus_addr", bus_addr, 32'h3000);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check("rstw.wait_req",   bus_req, 1'b0);
        check("rstw.wait_stall", stall,   1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        check("rstw.after_req",   bus_req,   1'b0);
        check("rstw.after_stall", stall,     1'b0);
        check("rstw.after_load",  load_data, 64'h0);
        bus_rvalid = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b0;
        check("rstw.late_rvalid", load_data, 64'h0);
        check("rstw.late_req",    bus_req,   1'b0);
        last_load = '0;

        // FSM is back in IDLE and handles a normal load.
        run_access("lbu_after", 1'b1, 1'b0, 1'b1, 2'b00, 64'h1003, 64'h0,
                   64'h0000_0000_8000_0000, 0, 0,
                   32'h1000, 8'h08, 64'h0, 64'h0000_0000_0000_0080);

        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
